// File: rtl/clk_pkg.sv
// Shared definitions for the clock divider: state encoding and reset ratio.
package clk_pkg;

   // Half-period (in clk_in cycles) used until software loads a ratio.
   localparam int unsigned CLK_RESET_HALF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } clk_state_e;

   // RUN and STOP both count as "generating"; only IDLE is quiet.
   function automatic logic is_active(input clk_state_e s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/clock_divider_half_cnt.sv
// Half-period counter: counts 0..half-1, wraps to 0, flags the last count.
module half_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic [WIDTH-1:0] half,
   output logic             term
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Terminal when the count reaches the last cycle of the half-period.
   assign term = (cnt_q == (half - ONE));

   // Next count: clear wins, otherwise advance and wrap on terminal.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = term ? '0 : (cnt_q + ONE);
      end
   end

   // Count register.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clock_divider.sv
// Programmable 50%-duty clock divider with glitch-free ratio updates and
// graceful stop (a high phase always completes before the output parks low).
module clock_divider
   import clk_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int RESET_HALF = CLK_RESET_HALF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic             upd_pend,
   output logic             active
);

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_HALF);

   clk_state_e       state_q, state_d;
   logic [WIDTH-1:0] half_q, half_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;

   logic             cnt_clr;
   logic             cnt_run;
   logic             cnt_term;
   logic             enter_idle;
   logic             rise;
   logic [WIDTH-1:0] load_val;

   // A zero ratio would never terminate; treat it as the fastest ratio.
   assign load_val = (div_val == '0) ? ONE : div_val;

   half_cnt #(
      .WIDTH (WIDTH)
   ) u_half_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (cnt_clr),
      .run    (cnt_run),
      .half   (half_q),
      .term   (cnt_term)
   );

   // Next-state, output level and ratio bookkeeping.
   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_run    = 1'b0;
      enter_idle = 1'b0;
      rise       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            clk_d   = 1'b0;
            if (div_load) begin
               half_d = load_val;
            end
            if (en) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!en && !clk_q) begin
               // Low phase can be cut short safely: output is already low.
               state_d    = ST_IDLE;
               cnt_clr    = 1'b1;
               enter_idle = 1'b1;
            end else begin
               cnt_run = 1'b1;
               if (cnt_term) begin
                  clk_d = ~clk_q;
               end
               if (!en) begin
                  state_d = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            if (clk_q) begin
               // Finish the high phase at full length, then fall.
               cnt_run = 1'b1;
               if (cnt_term) begin
                  clk_d = 1'b0;
               end
            end else begin
               state_d    = ST_IDLE;
               cnt_clr    = 1'b1;
               enter_idle = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            clk_d   = 1'b0;
         end
      endcase

      rise   = ~clk_q & clk_d;
      tick_d = rise;

      // While generating, new ratios are held and only applied on a rising
      // edge (or on the way back to IDLE) so no phase is ever truncated.
      if (state_q != ST_IDLE) begin
         if (enter_idle) begin
            if (div_load) begin
               half_d = load_val;
            end else if (pend_vld_q) begin
               half_d = pend_q;
            end
            pend_vld_d = 1'b0;
         end else begin
            if (rise && pend_vld_q) begin
               half_d     = pend_q;
               pend_vld_d = 1'b0;
            end
            if (div_load) begin
               pend_d     = load_val;
               pend_vld_d = 1'b1;
            end
         end
      end
   end

   // State and output registers; reset overrides every input.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         half_q     <= RST_H;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_q      <= clk_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out  = clk_q;
   assign tick     = tick_q;
   assign upd_pend = pend_vld_q;
   assign active   = is_active(state_q);

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter WIDTH, default 8, is the width of the divide-value datapath.
REQ-002 Parameter RESET_HALF, default 2, is the half-period value loaded at reset.
REQ-003 clk_in  input  1  is the single clock; all logic SHALL be rising-edge clk_in only.
REQ-004 rst  input  1  is the reset, synchronous, active-high.
REQ-005 en  input  1  requests divided-clock generation.
REQ-006 div_load  input  1  is a one-cycle strobe to capture div_val.
REQ-007 div_val  input  WIDTH  is the requested half-period in clk_in cycles.
REQ-008 clk_out  output  1  is the divided clock, driven directly from a register.
REQ-009 tick  output  1  is a one-cycle pulse in the first clk_in cycle that clk_out is high.
REQ-010 upd_pend  output  1  is high while a loaded ratio waits to be applied.
REQ-011 active  output  1  is high in the RUN and STOP states.

Function
REQ-012 A div_val of 0 SHALL be treated as 1; the effective half-period is H in 1..2^WIDTH-1.
REQ-013 The state machine SHALL have the states IDLE, RUN and STOP.
REQ-014 In IDLE, clk_out=0 and cnt=0; en=1 sampled at edge k -> RUN at k with cnt=0.
REQ-015 In RUN, cnt SHALL count 0..H-1; at cnt==H-1, cnt<=0 and clk_out toggles, giving period 2H and 50% duty.
REQ-016 From en sampled at edge k, the first clk_out rise SHALL occur at edge k+H.
REQ-017 tick<=1 on the edge where clk_out goes 0->1, and SHALL be 0 otherwise.
REQ-018 div_load in IDLE SHALL update H immediately; upd_pend stays 0.
REQ-019 div_load in RUN or STOP SHALL store div_val in a pending register and set upd_pend.
REQ-020 A pending value SHALL be applied only at a clk_out 0->1 edge, where it becomes the new H for that high phase, and upd_pend clears.
REQ-021 If div_load coincides with a rising edge, the new value SHALL wait for the next rising edge; a later load overwrites an unapplied one.
REQ-022 en=0 in RUN with clk_out=0 -> IDLE at the same edge, with no further toggles.
REQ-023 en=0 in RUN with clk_out=1 -> STOP; the current high phase completes at full length, clk_out falls, then -> IDLE.
REQ-024 en in STOP SHALL be ignored; re-enable is taken only from IDLE.
REQ-025 A pending value still held on entering IDLE SHALL be applied on that IDLE entry.
REQ-026 clk_out SHALL never show a high or low phase shorter than min(H_old, H_new) cycles.

Reset
REQ-027 rst (sync, priority over all inputs) SHALL force: state=IDLE, cnt=0, H=RESET_HALF, pending=0, clk_out=0, tick=0, upd_pend=0, active=0.
REQ-028 rst asserted mid-period SHALL abort the period at the next edge with no extra toggle.

Structure
REQ-029 The state encoding (IDLE/RUN/STOP) and the RESET_HALF default SHALL live in the shared package clk_pkg.
REQ-030 The module SHALL be one flat block; the cnt compare may be factored into the sub-module half_cnt (count, wrap, terminal flag).
REQ-031 No combinational path SHALL exist from any input to clk_out or tick.

Verification
REQ-032 rst, then en=1, default H=2 -> clk_out period 4, first rise 2 cycles after en, tick once per period.
REQ-033 In IDLE, load div_val=0 -> H=1, clk_out toggles every cycle (period 2).
REQ-034 H=3 running, load div_val=5 mid low phase -> upd_pend=1 until the next rise; the high phase is 3 before the rise and 5 after.
REQ-035 H=4, drop en at the 2nd high cycle -> clk_out stays high 2 more cycles, falls, active=0 one edge later; en pulses during STOP are ignored.
REQ-036 rst asserted 1 cycle after a rise with H=6 -> next edge clk_out=0, tick=0, upd_pend=0, H=2.
